// File: rtl/shift_sequencer_pkg.sv
// Shared op encodings, FSM states and op classification for the shift sequencer.
package shift_sequencer_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Ops that may be repeated by a burst.
    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Control/data bundle between a driver and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned S  = 1,
    parameter int unsigned CW = $clog2(N + 1)
) ();
    import shift_sequencer_pkg::*;

    logic            clr;
    logic [OP_W-1:0] op;
    logic [S-1:0]    s_in;
    logic [N-1:0]    p_in;
    logic            start;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    p_out;
    logic [S-1:0]    s_out_r;
    logic [S-1:0]    s_out_l;
    logic            busy;
    logic            done;

    modport master (
        output clr, op, s_in, p_in, start, cnt,
        input  p_out, s_out_r, s_out_l, busy, done
    );

    modport slave (
        input  clr, op, s_in, p_in, start, cnt,
        output p_out, s_out_r, s_out_l, busy, done
    );
endinterface

// File: rtl/shift_sequencer_shift_step.sv
// Combinational next register value for one op application.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned S = 1
) (
    input  logic [N-1:0] r,
    input  op_e          op,
    input  logic [S-1:0] s_in,
    input  logic [N-1:0] p_in,
    output logic [N-1:0] r_next
);

    // Select the op result; reserved code holds like HOLD.
    always_comb begin
        r_next = r;
        case (op)
            OP_SHL:  r_next = {r[N-S-1:0], s_in};
            OP_SHR:  r_next = {s_in, r[N-1:S]};
            OP_LOAD: r_next = p_in;
            OP_ROL:  r_next = {r[N-S-1:0], r[N-1:N-S]};
            OP_ROR:  r_next = {r[S-1:0], r[N-1:S]};
            OP_ASR:  r_next = {{S{r[N-1]}}, r[N-1:S]};
            default: r_next = r;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shift register with single-op mode and counted shift bursts.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned S  = 1,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    shift_sequencer_if.slave bus
);

    state_e        state_q, state_d;
    logic [N-1:0]  r_q, r_d, r_next;
    logic [CW-1:0] cnt_q, cnt_d;
    op_e           op_q, op_d;
    op_e           op_in, step_op;
    logic          burst_ok;
    logic          busy_q, done_q;

    assign op_in    = op_e'(bus.op);
    assign burst_ok = is_shift(op_in) && (bus.cnt != '0);
    // A running burst replays the captured op; otherwise the live op is used.
    assign step_op  = (state_q == ST_RUN) ? op_q : op_in;

    shift_step #(.N(N), .S(S)) u_step (
        .r      (r_q),
        .op     (step_op),
        .s_in   (bus.s_in),
        .p_in   (bus.p_in),
        .r_next (r_next)
    );

    // FSM state register; busy/done registered from the next state so they track state only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Next-state logic: clear wins, then burst sequencing.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) state_d = burst_ok ? ST_RUN : ST_DONE;
                ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values for register, step counter and captured op.
    always_comb begin
        r_d   = r_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (bus.clr) begin
            r_d   = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.start) begin
                        r_d = r_next;
                    end else if (burst_ok) begin
                        cnt_d = bus.cnt;
                        op_d  = op_in;
                    end
                end
                ST_RUN: begin
                    r_d   = r_next;
                    cnt_d = cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            cnt_q <= '0;
            op_q  <= OP_HOLD;
        end else begin
            r_q   <= r_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    assign bus.p_out   = r_q;
    assign bus.s_out_r = r_q[S-1:0];
    assign bus.s_out_l = r_q[N-1:N-S];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter N, default 8: register width in bits; SHALL be at least 2.
REQ-002 Parameter S, default 1: bits moved per shift step; SHALL satisfy 1 <= S <= N-1.
REQ-003 Parameter CW, default clog2(N+1): width of the burst-count input.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear of the register; also aborts a burst.
REQ-007 op  in  3  operation code, defined in REQ-012.
REQ-008 s_in  in  S  serial fill bits for SHL and SHR.
REQ-009 p_in  in  N  parallel-load data.
REQ-010 start, cnt  in  1, CW  burst request and burst step count.
REQ-011 p_out (out, N) = register; s_out_r (out, S) = register[S-1:0]; s_out_l (out, S) = register[N-1:N-S]; busy (out, 1); done (out, 1).

Function
REQ-012 op encoding SHALL be:
- 000 HOLD
- 001 SHL: {r[N-S-1:0], s_in}
- 010 SHR: {s_in, r[N-1:S]}
- 011 LOAD: p_in
- 100 ROL: rotate left by S
- 101 ROR: rotate right by S
- 110 ASR: right shift by S, sign-filled from r[N-1]
- 111 reserved, behaves as HOLD
REQ-013 Shift ops SHALL be SHL, SHR, ROL, ROR and ASR.
REQ-014 FSM states SHALL be IDLE, RUN and DONE; busy = (RUN or DONE); done = DONE. Both outputs SHALL be Moore outputs derived from state only.
REQ-015 IDLE with start=0: op SHALL be applied at every edge, so LOAD, shift and HOLD take effect with 1-cycle latency.
REQ-016 IDLE with start=1, a shift op and cnt>0: at that edge the FSM SHALL capture op and cnt, go to RUN, and leave the register unchanged.
REQ-017 IDLE with start=1 and either cnt=0 or a non-shift op: the FSM SHALL go to DONE and leave the register unchanged.
REQ-018 RUN: each edge SHALL apply the captured op (with the current s_in) and decrement the counter. The edge that consumes the last step SHALL move the FSM to DONE, so cnt=k gives exactly k shifts.
REQ-019 RUN and DONE: op, start, cnt and p_in SHALL be ignored; s_in is still sampled in RUN.
REQ-020 DONE SHALL last exactly 1 cycle, hold the register, and return to IDLE; a start asserted during DONE is dropped.
REQ-021 Timing: start sampled at edge 0 -> shifts at edges 1..k -> done high between edges k and k+1 -> IDLE after edge k+1.
REQ-022 cnt > N is legal; shifting continues. Rotates wrap modulo N; SHL/SHR keep filling from s_in; ASR saturates to all sign bits.
REQ-023 Priority SHALL be clr > burst/FSM > op.
REQ-024 clr=1 in any state SHALL set the register and counter to 0 and the FSM to IDLE; no done pulse is produced.

Reset
REQ-025 reset_n low SHALL immediately (asynchronously) set the register to 0, the counter to 0, the FSM to IDLE, and busy and done to 0.
REQ-026 Reset during RUN or DONE SHALL abort the burst with no done pulse; operation resumes in IDLE after release.

Structure
REQ-027 A shared package SHALL hold the op encodings (localparams or enum) and the FSM state enum.
REQ-028 The next-value function SHALL be a combinational sub-module, shift_step (parameters N and S; inputs r, op, s_in, p_in; output r_next), used by both the IDLE path and the RUN path.
REQ-029 The counter SHALL be CW bits wide and only decrement while in RUN.

Verification (N=8, S=1 unless stated)
REQ-030 Load and shift: LOAD p_in=0xA5, then SHL with s_in=1 -> p_out=0xA5, then 0x4B; s_out_l=1 before the shift.
REQ-031 Rotate burst: register=0x81, start, op=ROL, cnt=3 -> busy for 4 cycles; p_out 0x03, 0x06, 0x0C; done pulses once; final value 0x0C.
REQ-032 ASR burst: register=0x80, start, op=ASR, cnt=10 -> 10 shifts; final value 0xFF; done high exactly 1 cycle.
REQ-033 Null bursts: cnt=0, and separately op=LOAD with cnt=5 -> each gives done on the next cycle; register unchanged.
REQ-034 Aborts: clr at the 2nd RUN cycle -> p_out=0, IDLE, no done. Separately, reset_n low mid-burst -> all outputs 0 immediately.
REQ-035 Wide step, N=16 and S=4: register=0x1234, SHR with s_in=0xF -> 0xF123.
